fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one-outstanding request FSM feeding a
// two-entry registered instruction buffer, with redirect/drop handling.

package rv32i_pkg;
    parameter int unsigned XLEN = 32;
    parameter int unsigned ILEN = 32;
endpackage

module fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_gnt_in,
    input  logic            imem_rvalid_in,
    input  logic [ILEN-1:0] imem_rdata_in,
    output logic            instr_valid_out,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    input  logic            instr_ready_in,
    input  logic            redirect_in,
    input  logic [XLEN-1:0] redirect_pc_in
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DROP
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic            head_v_q, head_v_d;
    logic [ILEN-1:0] head_instr_q, head_instr_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic            tail_v_q, tail_v_d;
    logic [ILEN-1:0] tail_instr_q, tail_instr_d;
    logic [XLEN-1:0] tail_pc_q, tail_pc_d;

    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] resp_pc;
    logic [1:0]      cnt;
    logic [1:0]      cnt_post;
    logic            pop;
    logic            push;

    assign redir_pc = redirect_pc_in & ~XLEN'(3);
    // The response in RESP always belongs to the address just before fetch_pc.
    assign resp_pc  = fetch_pc_q - XLEN'(4);
    assign cnt      = {1'b0, head_v_q} + {1'b0, tail_v_q};
    assign pop      = head_v_q & instr_ready_in;
    assign cnt_post = cnt + 2'd1 - {1'b0, pop};

    // Fetch FSM: next state, fetch PC and pending redirect target.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_in) begin
                    fetch_pc_d = redir_pc;
                    state_d    = REQ;
                end else if (cnt < 2'd2) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt_in) begin
                    pend_d = 1'b0;
                    if (redirect_in) begin
                        fetch_pc_d = redir_pc;
                        state_d    = DROP;
                    end else if (pend_q) begin
                        fetch_pc_d = pend_pc_q;
                        state_d    = DROP;
                    end else begin
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                        state_d    = RESP;
                    end
                end else if (redirect_in) begin
                    // Old request stays on the bus until granted.
                    pend_d    = 1'b1;
                    pend_pc_d = redir_pc;
                end
            end
            RESP: begin
                if (redirect_in) begin
                    fetch_pc_d = redir_pc;
                    state_d    = imem_rvalid_in ? REQ : DROP;
                end else if (imem_rvalid_in) begin
                    push    = 1'b1;
                    state_d = (cnt_post < 2'd2) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirect_in) begin
                    fetch_pc_d = redir_pc;
                end
                if (imem_rvalid_in) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry buffer: head is the registered decode output, tail is spill.
    always_comb begin
        head_v_d     = head_v_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_v_d     = tail_v_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        if (redirect_in) begin
            head_v_d = 1'b0;
            tail_v_d = 1'b0;
        end else begin
            if (pop) begin
                head_v_d = tail_v_q;
                tail_v_d = 1'b0;
                if (tail_v_q) begin
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                end
            end
            if (push) begin
                if (!head_v_d) begin
                    head_v_d     = 1'b1;
                    head_instr_d = imem_rdata_in;
                    head_pc_d    = resp_pc;
                end else begin
                    tail_v_d     = 1'b1;
                    tail_instr_d = imem_rdata_in;
                    tail_pc_d    = resp_pc;
                end
            end
        end
    end

    // State and buffer registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            head_v_q     <= 1'b0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            tail_v_q     <= 1'b0;
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            head_v_q     <= head_v_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_v_q     <= tail_v_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    assign imem_req_out    = (state_q == REQ);
    assign imem_addr_out   = fetch_pc_q;
    assign instr_valid_out = head_v_q;
    assign instr_out       = head_instr_q;
    assign pc_out          = head_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: cycle table plus reset and
// idle-redirect sequences.

module tb_fetch_ctrl;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ivalid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        redir;
    logic [31:0] redir_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .imem_req_out    (req),
        .imem_addr_out   (addr),
        .imem_gnt_in     (gnt),
        .imem_rvalid_in  (rvalid),
        .imem_rdata_in   (rdata),
        .instr_valid_out (ivalid),
        .instr_out       (instr),
        .pc_out          (pc),
        .instr_ready_in  (ready),
        .redirect_in     (redir),
        .redirect_pc_in  (redir_pc)
    );

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] iw(input int n);
        return 32'hC0DE_0000 + 32'(n);
    endfunction

    function automatic vec_t mk(
        input logic g, input logic r, input logic [31:0] d,
        input logic y, input logic rd, input logic [31:0] rp,
        input logic eq, input logic [31:0] ea, input logic ev,
        input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rv = r; v.rdata = d; v.rdy = y;
        v.rd = rd; v.rpc = rp; v.e_req = eq; v.e_addr = ea;
        v.e_val = ev; v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eq,
                           input logic [31:0] ea, input logic ev,
                           input logic [31:0] ei, input logic [31:0] ep);
        chk({tag, " req"},   32'(req),    32'(eq));
        chk({tag, " addr"},  addr,        ea);
        chk({tag, " valid"}, 32'(ivalid), 32'(ev));
        chk({tag, " instr"}, instr,       ei);
        chk({tag, " pc"},    pc,          ep);
    endtask

    initial begin
        rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        ready = 1'b0; redir = 1'b0; redir_pc = '0;

        //          gnt rv rdata  rdy rd rpc          req addr         v  instr  pc
        tbl.push_back(mk(1, 0, 0,      1, 0, 0,           0, 32'h0,        0, 0,      0));
        tbl.push_back(mk(1, 0, 0,      1, 0, 0,           1, 32'h0,        0, 0,      0));
        tbl.push_back(mk(1, 1, iw(0),  1, 0, 0,           0, 32'h4,        0, 0,      0));
        tbl.push_back(mk(1, 0, 0,      1, 0, 0,           1, 32'h4,        1, iw(0),  32'h0));
        tbl.push_back(mk(1, 1, iw(1),  1, 0, 0,           0, 32'h8,        0, iw(0),  32'h0));
        tbl.push_back(mk(1, 0, 0,      1, 0, 0,           1, 32'h8,        1, iw(1),  32'h4));
        tbl.push_back(mk(1, 1, iw(2),  1, 0, 0,           0, 32'hC,        0, iw(1),  32'h4));
        tbl.push_back(mk(1, 0, 0,      0, 0, 0,           1, 32'hC,        1, iw(2),  32'h8));
        tbl.push_back(mk(1, 1, iw(3),  0, 0, 0,           0, 32'h10,       1, iw(2),  32'h8));
        tbl.push_back(mk(1, 0, 0,      0, 0, 0,           0, 32'h10,       1, iw(2),  32'h8));
        tbl.push_back(mk(1, 0, 0,      1, 0, 0,           0, 32'h10,       1, iw(2),  32'h8));
        tbl.push_back(mk(1, 0, 0,      0, 0, 0,           0, 32'h10,       1, iw(3),  32'hC));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,           1, 32'h10,       1, iw(3),  32'hC));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,           1, 32'h10,       1, iw(3),  32'hC));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,           1, 32'h10,       1, iw(3),  32'hC));
        tbl.push_back(mk(1, 0, 0,      0, 0, 0,           1, 32'h10,       1, iw(3),  32'hC));
        tbl.push_back(mk(1, 0, 0,      0, 0, 0,           0, 32'h14,       1, iw(3),  32'hC));
        tbl.push_back(mk(1, 0, 0,      0, 1, 32'h103,     0, 32'h14,       1, iw(3),  32'hC));
        tbl.push_back(mk(1, 1, iw(4),  0, 0, 0,           0, 32'h100,      0, iw(3),  32'hC));
        tbl.push_back(mk(1, 0, 0,      0, 0, 0,           1, 32'h100,      0, iw(3),  32'hC));
        tbl.push_back(mk(1, 1, iw(5),  0, 0, 0,           0, 32'h104,      0, iw(3),  32'hC));
        tbl.push_back(mk(1, 0, 0,      0, 0, 0,           1, 32'h104,      1, iw(5),  32'h100));
        tbl.push_back(mk(1, 1, iw(6),  1, 1, 32'h200,     0, 32'h108,      1, iw(5),  32'h100));
        tbl.push_back(mk(0, 0, 0,      0, 1, 32'h300,     1, 32'h200,      0, iw(5),  32'h100));
        tbl.push_back(mk(1, 0, 0,      0, 0, 0,           1, 32'h200,      0, iw(5),  32'h100));
        tbl.push_back(mk(1, 0, 0,      0, 1, 32'hFFFFFFFF,0, 32'h300,      0, iw(5),  32'h100));
        tbl.push_back(mk(1, 1, iw(7),  0, 0, 0,           0, 32'hFFFFFFFC, 0, iw(5),  32'h100));
        tbl.push_back(mk(1, 0, 0,      0, 0, 0,           1, 32'hFFFFFFFC, 0, iw(5),  32'h100));
        tbl.push_back(mk(1, 1, iw(8),  0, 0, 0,           0, 32'h0,        0, iw(5),  32'h100));
        tbl.push_back(mk(0, 1, iw(9),  1, 0, 0,           1, 32'h0,        1, iw(8),  32'hFFFFFFFC));
        tbl.push_back(mk(1, 0, 0,      0, 1, 32'h40,      1, 32'h0,        0, iw(8),  32'hFFFFFFFC));
        tbl.push_back(mk(1, 1, iw(10), 0, 0, 0,           0, 32'h40,       0, iw(8),  32'hFFFFFFFC));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,           1, 32'h40,       0, iw(8),  32'hFFFFFFFC));

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            gnt      = tbl[i].gnt;
            rvalid   = tbl[i].rv;
            rdata    = tbl[i].rdata;
            ready    = tbl[i].rdy;
            redir    = tbl[i].rd;
            redir_pc = tbl[i].rpc;
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                    tbl[i].e_val, tbl[i].e_instr, tbl[i].e_pc);
            @(posedge clk);
            #1;
        end

        // Grant a request, then reset while its response is outstanding.
        gnt = 1'b1; rvalid = 1'b0; ready = 1'b0; redir = 1'b0;
        @(posedge clk);
        #1;
        chk("resp addr", addr, 32'h44);
        chk("resp req", 32'(req), 32'h0);
        rst_n = 1'b0;
        #1;
        chk_all("midreset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stale response in IDLE is ignored; redirect from IDLE fetches target.
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        redir = 1'b1; redir_pc = 32'h81;
        @(posedge clk);
        #1;
        chk_all("idle_redir", 1'b1, 32'h80, 1'b0, 32'h0, 32'h0);
        redir = 1'b0; rvalid = 1'b0; gnt = 1'b1;
        @(posedge clk);
        #1;
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_00AA;
        chk("post_redir addr", addr, 32'h84);
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        chk_all("post_redir", 1'b1, 32'h84, 1'b1, 32'hAA, 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
